// File: rtl/ahb_slave_port_mux.sv
// Per-slave AHB port mux: steers the granted master onto the slave port
// and routes ready/response back, with two-cycle ERROR cancellation.
module ahb_slave_port_mux #(
  parameter int MASTER_NUM = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                                hclk,
  input  logic                                hreset_n,
  input  logic [MASTER_NUM-1:0]               hgrant,
  input  logic                                hsel,
  input  logic [MASTER_NUM-1:0][ADDR_W-1:0]   m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]          m_htrans,
  input  logic [MASTER_NUM-1:0]               m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]          m_hsize,
  input  logic [MASTER_NUM-1:0][2:0]          m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_W-1:0]   m_hwdata,
  input  logic                                s_hreadyout,
  input  logic                                s_hresp,
  input  logic [DATA_W-1:0]                   s_hrdata,
  output logic                                s_hsel,
  output logic [ADDR_W-1:0]                   s_haddr,
  output logic [1:0]                          s_htrans,
  output logic                                s_hwrite,
  output logic [2:0]                          s_hsize,
  output logic [2:0]                          s_hburst,
  output logic [DATA_W-1:0]                   s_hwdata,
  output logic [MASTER_NUM-1:0]               m_hready,
  output logic [MASTER_NUM-1:0]               m_hresp,
  output logic [DATA_W-1:0]                   m_hrdata,
  output logic                                hwait,
  output logic [2:0]                          hburst
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [2:0] BURST_SINGLE = 3'b000;

  typedef enum logic {
    ST_OK,
    ST_ERR1
  } err_st_e;

  err_st_e               st_q;
  logic [MASTER_NUM-1:0] addr_owner_q;
  logic [MASTER_NUM-1:0] data_owner_q;
  logic [MASTER_NUM-1:0] data_owner_d;
  logic [MASTER_NUM-1:0] addr_sel;
  logic [1:0]            mux_htrans;

  // Grant wins; otherwise hold the owner through slave wait states.
  always_comb begin
    addr_sel = '0;
    if (hreset_n)
      addr_sel = (|hgrant) ? hgrant : addr_owner_q;
  end

  always_comb begin
    s_haddr    = '0;
    mux_htrans = TR_IDLE;
    s_hwrite   = 1'b0;
    s_hsize    = '0;
    s_hburst   = BURST_SINGLE;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (addr_sel[i]) begin
        s_haddr    = m_haddr[i];
        mux_htrans = m_htrans[i];
        s_hwrite   = m_hwrite[i];
        s_hsize    = m_hsize[i];
        s_hburst   = m_hburst[i];
      end
    end
  end

  assign s_htrans = (st_q == ST_ERR1) ? TR_IDLE : mux_htrans;
  assign s_hsel   = hsel & (|addr_sel);
  assign hburst   = s_hburst;

  always_comb begin
    data_owner_d = data_owner_q;
    if (s_hreadyout)
      data_owner_d = (s_hsel && s_htrans[1]) ? addr_sel : '0;
  end

  always_comb begin
    s_hwdata = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (data_owner_q[i])
        s_hwdata = m_hwdata[i];
    end
  end

  always_comb begin
    m_hready = '1;
    m_hresp  = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (data_owner_q[i] || addr_sel[i])
        m_hready[i] = s_hreadyout;
      if (data_owner_q[i])
        m_hresp[i] = s_hresp;
    end
  end

  assign hwait    = (|data_owner_q) & ~s_hreadyout;
  assign m_hrdata = s_hrdata;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
      st_q         <= ST_OK;
    end else begin
      addr_owner_q <= addr_sel;
      data_owner_q <= data_owner_d;
      case (st_q)
        ST_OK: begin
          if (s_hresp && !s_hreadyout && (|data_owner_q))
            st_q <= ST_ERR1;
        end
        ST_ERR1: begin
          if (s_hreadyout)
            st_q <= ST_OK;
        end
        default: st_q <= ST_OK;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Bench for ahb_slave_port_mux: directed scenarios then random traffic,
// all checked against an index-based transfer model.
module tb_ahb_slave_port_mux;

  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                hclk = 1'b0;
  logic                hreset_n;
  logic [M-1:0]        hgrant;
  logic                hsel;
  logic [M-1:0][AW-1:0] m_haddr;
  logic [M-1:0][1:0]   m_htrans;
  logic [M-1:0]        m_hwrite;
  logic [M-1:0][2:0]   m_hsize;
  logic [M-1:0][2:0]   m_hburst;
  logic [M-1:0][DW-1:0] m_hwdata;
  logic                s_hreadyout;
  logic                s_hresp;
  logic [DW-1:0]       s_hrdata;
  logic                s_hsel;
  logic [AW-1:0]       s_haddr;
  logic [1:0]          s_htrans;
  logic                s_hwrite;
  logic [2:0]          s_hsize;
  logic [2:0]          s_hburst;
  logic [DW-1:0]       s_hwdata;
  logic [M-1:0]        m_hready;
  logic [M-1:0]        m_hresp;
  logic [DW-1:0]       m_hrdata;
  logic                hwait;
  logic [2:0]          hburst;

  ahb_slave_port_mux #(
    .MASTER_NUM(M),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .hgrant     (hgrant),
    .hsel       (hsel),
    .m_haddr    (m_haddr),
    .m_htrans   (m_htrans),
    .m_hwrite   (m_hwrite),
    .m_hsize    (m_hsize),
    .m_hburst   (m_hburst),
    .m_hwdata   (m_hwdata),
    .s_hreadyout(s_hreadyout),
    .s_hresp    (s_hresp),
    .s_hrdata   (s_hrdata),
    .s_hsel     (s_hsel),
    .s_haddr    (s_haddr),
    .s_htrans   (s_htrans),
    .s_hwrite   (s_hwrite),
    .s_hsize    (s_hsize),
    .s_hburst   (s_hburst),
    .s_hwdata   (s_hwdata),
    .m_hready   (m_hready),
    .m_hresp    (m_hresp),
    .m_hrdata   (m_hrdata),
    .hwait      (hwait),
    .hburst     (hburst)
  );

  always #5 hclk = ~hclk;

  int nvec = 0;
  int nerr = 0;

  // Model state: master index owning address / data phase, -1 = none.
  int   aown = -1;
  int   down = -1;
  bit   err  = 1'b0;
  int   ag_c;
  bit   e_hsel_c;
  logic [1:0] e_htrans_c;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] e_addr;
    logic          e_wr;
    logic [2:0]    e_size;
    logic [2:0]    e_burst;
    logic [DW-1:0] e_wd;
    logic [M-1:0]  e_rdy;
    logic [M-1:0]  e_resp;
    if (!hreset_n) begin
      aown = -1;
      down = -1;
      err  = 1'b0;
    end
    ag_c = aown;
    for (int i = 0; i < M; i++)
      if (hgrant[i]) ag_c = i;
    if (!hreset_n) ag_c = -1;
    e_addr = '0;
    e_wr = 1'b0;
    e_size = '0;
    e_burst = '0;
    e_htrans_c = 2'b00;
    if (ag_c >= 0) begin
      e_addr  = m_haddr[ag_c];
      e_wr    = m_hwrite[ag_c];
      e_size  = m_hsize[ag_c];
      e_burst = m_hburst[ag_c];
      if (!err) e_htrans_c = m_htrans[ag_c];
    end
    e_hsel_c = hsel && (ag_c >= 0);
    e_wd = '0;
    if (down >= 0) e_wd = m_hwdata[down];
    for (int i = 0; i < M; i++) begin
      e_rdy[i]  = (i == down || i == ag_c) ? s_hreadyout : 1'b1;
      e_resp[i] = (i == down) ? s_hresp : 1'b0;
    end
    chk("s_hsel", s_hsel, e_hsel_c);
    chk("s_haddr", s_haddr, e_addr);
    chk("s_htrans", s_htrans, e_htrans_c);
    chk("s_hwrite", s_hwrite, e_wr);
    chk("s_hsize", s_hsize, e_size);
    chk("s_hburst", s_hburst, e_burst);
    chk("hburst", hburst, e_burst);
    chk("s_hwdata", s_hwdata, e_wd);
    chk("m_hready", m_hready, e_rdy);
    chk("m_hresp", m_hresp, e_resp);
    chk("m_hrdata", m_hrdata, s_hrdata);
    chk("hwait", hwait, (down >= 0) && !s_hreadyout);
  endtask

  task automatic upd();
    bit n_err;
    if (!hreset_n) begin
      aown = -1;
      down = -1;
      err  = 1'b0;
    end else begin
      n_err = err;
      if (!err && s_hresp && !s_hreadyout && down >= 0)
        n_err = 1'b1;
      else if (err && s_hreadyout)
        n_err = 1'b0;
      aown = ag_c;
      if (s_hreadyout)
        down = (e_hsel_c && e_htrans_c[1]) ? ag_c : -1;
      err = n_err;
    end
  endtask

  task automatic cyc();
    @(negedge hclk);
    check_all();
    @(posedge hclk);
    upd();
    #1;
  endtask

  task automatic rnd_inputs();
    for (int i = 0; i < M; i++) begin
      m_haddr[i]  = $urandom;
      m_htrans[i] = 2'($urandom_range(0, 3));
      m_hwrite[i] = 1'($urandom_range(0, 1));
      m_hsize[i]  = 3'($urandom_range(0, 2));
      m_hburst[i] = 3'($urandom_range(0, 7));
      m_hwdata[i] = $urandom;
    end
    if ($urandom_range(0, 3) == 0)
      hgrant = '0;
    else
      hgrant = 3'(1 << $urandom_range(0, 2));
    if (!s_hreadyout && $urandom_range(0, 7) != 0)
      hgrant = '0;
    hsel        = ($urandom_range(0, 4) != 0);
    s_hreadyout = ($urandom_range(0, 3) != 0);
    s_hresp     = ($urandom_range(0, 7) == 0);
    s_hrdata    = $urandom;
  endtask

  task automatic idle_all();
    hgrant = '0;
    for (int i = 0; i < M; i++) begin
      m_htrans[i] = 2'b00;
      m_hburst[i] = 3'b000;
    end
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
  endtask

  initial begin
    hreset_n    = 1'b0;
    s_hreadyout = 1'b1;
    rnd_inputs();
    #1;
    chk("rst_m_hready", m_hready, 3'b111);
    chk("rst_s_hsel", s_hsel, 1'b0);
    chk("rst_s_htrans", s_htrans, 2'b00);
    chk("rst_hwait", hwait, 1'b0);
    repeat (3) begin
      rnd_inputs();
      cyc();
    end

    hreset_n = 1'b1;
    idle_all();
    hsel = 1'b0;
    cyc();

    // single write from master 0
    hsel        = 1'b1;
    hgrant      = 3'b001;
    m_htrans[0] = 2'b10;
    m_haddr[0]  = 32'h100;
    m_hwrite[0] = 1'b1;
    m_hwdata[0] = 32'hA0A0_0001;
    #1;
    chk("wr_s_haddr", s_haddr, 32'h100);
    cyc();
    hgrant      = 3'b000;
    m_htrans[0] = 2'b00;
    #1;
    chk("wr_s_hwdata", s_hwdata, 32'hA0A0_0001);
    cyc();

    // three wait states in master 1 data phase
    hgrant      = 3'b010;
    m_htrans[1] = 2'b10;
    m_haddr[1]  = 32'h200;
    cyc();
    hgrant      = 3'b000;
    m_htrans[1] = 2'b00;
    s_hreadyout = 1'b0;
    repeat (3) begin
      #1;
      chk("ws_hwait", hwait, 1'b1);
      chk("ws_m_hready1", m_hready[1], 1'b0);
      chk("ws_s_haddr", s_haddr, 32'h200);
      cyc();
    end
    s_hreadyout = 1'b1;
    cyc();

    // INCR4 from master 0 handing over to master 2
    hgrant      = 3'b001;
    m_hburst[0] = 3'b011;
    for (int j = 0; j < 4; j++) begin
      m_htrans[0] = (j == 0) ? 2'b10 : 2'b11;
      m_haddr[0]  = 32'h300 + 32'(4 * j);
      m_hwdata[0] = $urandom;
      cyc();
    end
    hgrant      = 3'b100;
    m_htrans[0] = 2'b00;
    m_htrans[2] = 2'b10;
    m_haddr[2]  = 32'h400;
    s_hreadyout = 1'b0;
    #1;
    chk("ho_m_hready", m_hready, 3'b010);
    chk("ho_m_hresp", m_hresp, 3'b000);
    cyc();
    hgrant      = 3'b000;
    s_hreadyout = 1'b1;
    cyc();
    m_htrans[2] = 2'b00;
    cyc();

    // two-cycle ERROR during master 1 burst
    hgrant      = 3'b010;
    m_hburst[1] = 3'b001;
    m_htrans[1] = 2'b10;
    m_haddr[1]  = 32'h500;
    cyc();
    m_htrans[1] = 2'b11;
    m_haddr[1]  = 32'h504;
    cyc();
    hgrant      = 3'b000;
    m_haddr[1]  = 32'h508;
    s_hresp     = 1'b1;
    s_hreadyout = 1'b0;
    #1;
    chk("e1_m_hresp", m_hresp, 3'b010);
    chk("e1_s_htrans", s_htrans, 2'b11);
    cyc();
    s_hreadyout = 1'b1;
    #1;
    chk("e2_s_htrans", s_htrans, 2'b00);
    chk("e2_m_hresp", m_hresp, 3'b010);
    cyc();
    s_hresp     = 1'b0;
    m_htrans[1] = 2'b00;
    #1;
    chk("e3_m_hresp", m_hresp, 3'b000);
    chk("e3_s_hwdata", s_hwdata, 32'h0);
    cyc();

    // BUSY does not open a data phase
    hgrant      = 3'b001;
    m_htrans[0] = 2'b01;
    cyc();
    m_htrans[0] = 2'b00;
    #1;
    chk("busy_hwait", hwait, 1'b0);
    chk("busy_s_hwdata", s_hwdata, 32'h0);
    cyc();

    // reset in the middle of a stalled data phase
    hgrant      = 3'b100;
    m_htrans[2] = 2'b10;
    cyc();
    hgrant      = 3'b000;
    s_hreadyout = 1'b0;
    #1;
    chk("mr_hwait_pre", hwait, 1'b1);
    hreset_n = 1'b0;
    #1;
    chk("mr_hwait", hwait, 1'b0);
    chk("mr_m_hready", m_hready, 3'b111);
    chk("mr_s_hsel", s_hsel, 1'b0);
    cyc();
    hreset_n = 1'b1;
    idle_all();
    cyc();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rnd_inputs();
      hreset_n = ($urandom_range(0, 59) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
